// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: drives all 16 {a,b,c,d} vectors, samples y after a dwell, and compares against a latched golden truth table.
module tt_sweep_capture #(
    parameter int unsigned DWELL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        y,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic [15:0] tt,
    output logic [4:0]  mismatch_cnt,
    output logic        busy,
    output logic        done,
    output logic        pass
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] tt_q, tt_d;
    logic [4:0]  mm_q, mm_d;
    logic [3:0]  vec_q, vec_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        mm_d    = mm_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = DRIVE;
                exp_d   = expected;
                tt_d    = '0;
                mm_d    = '0;
                idx_d   = '0;
                dwell_d = '0;
            end
            DRIVE: if (dwell_q == DWELL_LAST) state_d = SAMPLE;
                   else dwell_d = dwell_q + 8'd1;
            SAMPLE: begin
                tt_d[idx_q] = y;
                mm_d        = mm_q + {4'd0, y ^ exp_q[idx_q]};
                dwell_d     = '0;
                if (idx_q == 4'hF) state_d = DONE;
                else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = DRIVE;
                end
            end
        endcase
        // stimulus is registered from the next state so it lines up with the state it belongs to
        vec_d = (state_d == DONE) ? 4'hF : (state_d == IDLE) ? 4'h0 : idx_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            mm_q    <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            mm_q    <= mm_d;
            vec_q   <= vec_d;
        end
    end

    assign {a, b, c, d}  = vec_q;
    assign tt            = tt_q;
    assign mismatch_cnt  = mm_q;
    assign busy          = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done          = (state_q == DONE);
    assign pass          = done && (mm_q == 5'd0);
endmodule
